// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use/branch stall detection and the divider busy sequencer.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int DIV_LATENCY = 33,
  parameter int CNT_W       = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       StartDivE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushE,
  output logic       FlushM,
  output logic       DivBusy,
  output logic       DivDone
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] PerfStallCycles,
  output logic [31:0] PerfLoadUse
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             lwstall;
  logic             brstall;
  logic             hazard;

  // DONE ignores StartDivE because the finishing DIV is still sitting in E.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (StartDivE) begin
            state <= BUSY;
            cnt   <= CNT_W'(DIV_LATENCY - 2);
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == BUSY);
  assign DivBusy = busy;
  assign DivDone = (state == DONE);

  assign lwstall = MemtoRegE && RegWriteE && (WriteRegE != 5'd0) &&
                   ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign brstall = BranchD &&
                   ((RegWriteE && (WriteRegE != 5'd0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && (WriteRegM != 5'd0) &&
                     ((WriteRegM == RsD) || (WriteRegM == RtD))));
  assign hazard  = lwstall || brstall;

  // M-stage results win over W-stage results; r0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!reset) begin
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE))      ForwardAE = 2'b10;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE)) ForwardAE = 2'b01;
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE))      ForwardBE = 2'b10;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE)) ForwardBE = 2'b01;
      ForwardAD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
      ForwardBD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD);
    end
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (!reset) begin
      if (busy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else begin
        StallF = hazard;
        StallD = hazard;
        FlushE = hazard;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Load-use stalls hidden behind a divider freeze are not counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      PerfStallCycles <= '0;
      PerfLoadUse     <= '0;
    end else begin
      if (StallF)             PerfStallCycles <= PerfStallCycles + 32'd1;
      if (lwstall && !busy)   PerfLoadUse     <= PerfLoadUse + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: random and directed stimulus against a cycle-schedule model.
// Perf counter checks are included when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  localparam int L = 33;

  logic       clock;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, StartDivE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE, FlushM, DivBusy, DivDone;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfStallCycles, PerfLoadUse;
`endif

  hazard_ctrl #(.DIV_LATENCY(L), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .StartDivE(StartDivE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM),
    .DivBusy(DivBusy), .DivDone(DivDone)
`ifdef HAZARD_PERF_EN
    , .PerfStallCycles(PerfStallCycles), .PerfLoadUse(PerfLoadUse)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [12:0] obs;
  assign obs = {ForwardAE, ForwardBE, ForwardAD, ForwardBD,
                StallF, StallD, StallE, FlushE, FlushM, DivBusy, DivDone};

  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  int          div_start = -1000;
  logic [12:0] exp_vec;
  logic        m_busy, m_done, m_stallf, m_lu;
  int unsigned perf_stall = 0;
  int unsigned perf_lu    = 0;

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic fwd_d(input logic [4:0] src);
    return RegWriteM && WriteRegM != 5'd0 && WriteRegM == src;
  endfunction

  function automatic logic hits_d(input logic [4:0] dst);
    return dst != 5'd0 && (dst == RsD || dst == RtD);
  endfunction

  // The divider is modelled as a schedule relative to the cycle its DIV was accepted.
  task automatic evaluate();
    logic lw, br, hz;
    #1;
    m_busy = (cyc - div_start >= 1) && (cyc - div_start <= L - 1);
    m_done = (cyc - div_start == L);
    lw = MemtoRegE && RegWriteE && hits_d(WriteRegE);
    br = BranchD && ((RegWriteE && hits_d(WriteRegE)) || (MemtoRegM && hits_d(WriteRegM)));
    hz = lw || br;
    if (reset) begin
      exp_vec  = {11'b0, m_busy, m_done};
      m_stallf = 1'b0;
      m_lu     = 1'b0;
    end else begin
      exp_vec  = {fwd_e(RsE), fwd_e(RtE), fwd_d(RsD), fwd_d(RtD),
                  m_busy | hz, m_busy | hz, m_busy, !m_busy & hz, m_busy, m_busy, m_done};
      m_stallf = m_busy | hz;
      m_lu     = lw & !m_busy;
    end
  endtask

  task automatic tick();
    if (reset) begin
      div_start  = -1000;
      perf_stall = 0;
      perf_lu    = 0;
    end else begin
      if (!m_busy && !m_done && StartDivE) div_start = cyc;
      perf_stall += 32'(m_stallf);
      perf_lu    += 32'(m_lu);
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, StartDivE} = '0;
  endtask

  task automatic randomize_regs();
    RsD = 5'($urandom_range(0, 3));  RtD = 5'($urandom_range(0, 3));
    RsE = 5'($urandom_range(0, 3));  RtE = 5'($urandom_range(0, 3));
    WriteRegE = 5'($urandom_range(0, 3));
    WriteRegM = 5'($urandom_range(0, 3));
    WriteRegW = 5'($urandom_range(0, 3));
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD} = 6'($urandom);
  endtask

  task automatic apply_reset();
    set_idle();
    reset = 1'b1;
    evaluate();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    RegWriteM = 1'b1; WriteRegM = 5'd8; RsE = 5'd8; RsD = 5'd8;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
    evaluate();
    total++;
    if (obs !== 13'b0) $display("FAIL reset_hold got=%b exp=%b", obs, 13'b0);
    else passed++;
    tick();
    reset = 1'b0;
    evaluate();
    total++;
    if (obs !== exp_vec) $display("FAIL reset_release got=%b exp=%b", obs, exp_vec);
    else passed++;
    tick();
  endtask

  task automatic test_forwarding();
    set_idle();
    RegWriteM = 1'b1; WriteRegM = 5'd8; RsE = 5'd8; RegWriteW = 1'b1; WriteRegW = 5'd8;
    evaluate();
    total++;
    if (ForwardAE !== 2'b10) $display("FAIL fwd_m_prio got=%b exp=10", ForwardAE);
    else passed++;
    tick();
    RegWriteM = 1'b0;
    evaluate();
    total++;
    if (ForwardAE !== 2'b01) $display("FAIL fwd_w got=%b exp=01", ForwardAE);
    else passed++;
    tick();
    WriteRegM = 5'd0; WriteRegW = 5'd0; RsE = 5'd0; RegWriteM = 1'b1;
    evaluate();
    total++;
    if (ForwardAE !== 2'b00) $display("FAIL fwd_r0 got=%b exp=00", ForwardAE);
    else passed++;
    tick();
    for (int i = 0; i < 60; i++) begin
      randomize_regs();
      StartDivE = 1'b0;
      evaluate();
      total++;
      if (obs !== exp_vec) $display("FAIL fwd_random cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
      else passed++;
      tick();
    end
  endtask

  task automatic test_load_use();
    set_idle();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
    evaluate();
    total++;
    if ({StallF, StallD, FlushE, StallE} !== 4'b1110)
      $display("FAIL load_use_stall got=%b exp=1110", {StallF, StallD, FlushE, StallE});
    else passed++;
    tick();
    set_idle();
    MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd9; RtE = 5'd9;
    evaluate();
    total++;
    if ({ForwardBE, StallF, FlushE} !== 4'b1000)
      $display("FAIL load_use_release got=%b exp=1000", {ForwardBE, StallF, FlushE});
    else passed++;
    tick();
  endtask

  task automatic test_branch();
    set_idle();
    BranchD = 1'b1; RsD = 5'd4; MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd4;
    evaluate();
    total++;
    if (obs !== exp_vec || StallD !== 1'b1)
      $display("FAIL branch_stall got=%b exp=%b", obs, exp_vec);
    else passed++;
    tick();
    MemtoRegM = 1'b0; RegWriteM = 1'b0; WriteRegM = 5'd0; RegWriteW = 1'b1; WriteRegW = 5'd4;
    evaluate();
    total++;
    if ({StallD, ForwardAD} !== 2'b00)
      $display("FAIL branch_release got=%b exp=00", {StallD, ForwardAD});
    else passed++;
    tick();
  endtask

  task automatic test_divider();
    set_idle();
    StartDivE = 1'b1;
    evaluate();
    total++;
    if ({DivBusy, StallF, StallE} !== 3'b000)
      $display("FAIL div_accept got=%b exp=000", {DivBusy, StallF, StallE});
    else passed++;
    tick();
    for (int i = 0; i < L - 1; i++) begin
      if (i == 5) begin
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd7; RsD = 5'd7;
      end else begin
        MemtoRegE = 1'b0; RegWriteE = 1'b0; WriteRegE = 5'd0; RsD = 5'd0;
      end
      evaluate();
      total++;
      if ({DivBusy, DivDone, StallF, StallD, StallE, FlushE, FlushM} !== 7'b1011101 ||
          obs !== exp_vec)
        $display("FAIL div_busy i=%0d got=%b exp=%b", i, obs, exp_vec);
      else passed++;
      tick();
    end
    evaluate();
    total++;
    if ({DivBusy, DivDone, StallF, StallE, FlushM} !== 5'b01000)
      $display("FAIL div_done got=%b exp=01000", {DivBusy, DivDone, StallF, StallE, FlushM});
    else passed++;
    tick();
    StartDivE = 1'b0;
    evaluate();
    total++;
    if ({DivBusy, DivDone} !== 2'b00 || obs !== exp_vec)
      $display("FAIL div_idle got=%b exp=%b", obs, exp_vec);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int busy_cycles;
    bit seen_done;
    set_idle();
    StartDivE = 1'b1;
    evaluate();
    tick();
    for (int i = 0; i < 9; i++) begin
      evaluate();
      total++;
      if (obs !== exp_vec) $display("FAIL abort_prefix i=%0d got=%b exp=%b", i, obs, exp_vec);
      else passed++;
      tick();
    end
    reset = 1'b1;
    evaluate();
    total++;
    if (obs !== exp_vec) $display("FAIL abort_reset got=%b exp=%b", obs, exp_vec);
    else passed++;
    tick();
    reset = 1'b0;
    StartDivE = 1'b0;
    evaluate();
    total++;
    if (obs !== 13'b0) $display("FAIL abort_after got=%b exp=%b", obs, 13'b0);
    else passed++;
    tick();
    StartDivE = 1'b1;
    evaluate();
    tick();
    busy_cycles = 0;
    seen_done = 1'b0;
    for (int i = 0; i < L + 8 && !seen_done; i++) begin
      evaluate();
      if (DivBusy === 1'b1) busy_cycles++;
      if (DivDone === 1'b1) seen_done = 1'b1;
      tick();
    end
    StartDivE = 1'b0;
    total++;
    if (!seen_done || busy_cycles != L - 1)
      $display("FAIL abort_restart busy=%0d done=%0d exp busy=%0d done=1", busy_cycles, seen_done, L - 1);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int dones;
    set_idle();
    StartDivE = 1'b1;
    dones = 0;
    for (int i = 0; i < 2 * (L + 1); i++) begin
      evaluate();
      if (DivDone === 1'b1) dones++;
      total++;
      if (obs !== exp_vec) $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
      else passed++;
      tick();
    end
    StartDivE = 1'b0;
    evaluate();
    total++;
    if (dones != 2 || DivBusy !== 1'b0) $display("FAIL b2b_count got=%0d exp=2", dones);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_regs();
      StartDivE = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 99) == 0);
      evaluate();
      total++;
      if (obs !== exp_vec) $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_vec);
      else passed++;
      tick();
    end
    reset = 1'b0;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    apply_reset();
    test_load_use();
    test_divider();
    total++;
    if (PerfLoadUse !== 32'd1) $display("FAIL perf_loaduse got=%0d exp=1", PerfLoadUse);
    else passed++;
    total++;
    if (PerfStallCycles !== 32'd33) $display("FAIL perf_stall got=%0d exp=33", PerfStallCycles);
    else passed++;
    test_random();
    total++;
    if (PerfStallCycles !== perf_stall || PerfLoadUse !== perf_lu)
      $display("FAIL perf_random got=%0d/%0d exp=%0d/%0d", PerfStallCycles, PerfLoadUse, perf_stall, perf_lu);
    else passed++;
  endtask
`endif

  initial begin
    set_idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_divider();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
